// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int XLEN = 64;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} pairs; flush dominates push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic         empty_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count alone define which slots are live.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule : fetch_fifo

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: sequential PC generation, credit-limited imem requests,
// response buffering and redirect handling with in-flight response discard.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              DEPTH     = 4,
  parameter int              MAX_OUTST = 2,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q,  resp_pc_d;
  logic [OW-1:0]   outst_q,    outst_d;
  logic [OW-1:0]   drop_q,     drop_d;

  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            push, pop;
  fetch_entry_t    push_entry, head_entry;
  logic [CW:0]     credit_used;
  logic            issue_fire, resp_ok;

  // Buffered entries plus requests in flight may never exceed DEPTH, so no response overflows.
  assign credit_used    = (CW+1)'(fifo_count) + (CW+1)'(outst_q);
  assign imem_req_valid = rst && !redirect_valid
                          && (outst_q < OW'(MAX_OUTST))
                          && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign issue_fire     = imem_req_valid && imem_req_ready;

  assign resp_ok    = imem_resp_valid && (outst_q != '0);
  assign push       = resp_ok && !redirect_valid && (drop_q == '0);
  assign push_entry = '{pc: resp_pc_q, instr: imem_resp_data};

  assign if_valid = !redirect_valid && !fifo_empty;
  assign pop      = if_valid && if_ready;
  assign if_instr = fifo_empty ? NOP_INSTR : head_entry.instr;
  assign if_pc    = fifo_empty ? '0 : head_entry.pc;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .head_o      (head_entry),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // NOTE: every _d gets a default before any branch, so no path leaves a latch.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    outst_d    = outst_q + OW'(issue_fire) - OW'(resp_ok);
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      // Everything still in flight after this cycle belongs to the abandoned stream.
      drop_d     = outst_q - OW'(resp_ok);
    end else begin
      if (issue_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (resp_ok) begin
        if (drop_q != '0) drop_d    = drop_q - OW'(1);
        else              resp_pc_d = resp_pc_q + XLEN'(4);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order pipelined imem model, stream-level
// reference model of delivered {pc, instr}, and a monitor that scores every handshake.
module tb_fetch_unit;

  localparam int          DEPTH      = 4;
  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam int          STREAM_LEN = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data  = 32'h0;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [63:0] if_pc;

  fetch_unit #(.DEPTH(DEPTH), .MAX_OUTST(2), .RESET_PC(64'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B9) ^ a[63:32] ^ 32'h5A5A_0001;
  endfunction

  // Reference stream: after reset/redirect to S, decode must see S, S+4, S+8, ... exactly once each.
  logic [63:0] exp_q[$];
  int          epoch = 0;
  int          delivered = 0;
  int          occ = 0;

  task automatic restart_stream(input logic [63:0] start);
    exp_q.delete();
    for (int i = 0; i < STREAM_LEN; i++) exp_q.push_back(start + 64'(4 * i));
    epoch++;
  endtask

  // In-order pipelined memory with a programmable latency; requests are tagged with the stream epoch.
  typedef struct {
    longint      due;
    logic [63:0] addr;
    int          ep;
  } mreq_t;

  mreq_t  pend[$];
  longint cyc = 0;
  int     mem_lat = 1;
  bit     resp_fresh = 1'b0;
  bit     watch_200 = 1'b0;
  bit     saw_200 = 1'b0;

  always begin
    mreq_t m;
    @(negedge clk);
    if (rst && imem_req_valid && imem_req_ready)
      pend.push_back('{cyc + longint'(mem_lat), imem_req_addr, epoch});
    if (watch_200 && rst && imem_req_valid && imem_req_addr == 64'h200) saw_200 = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      m = pend.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(m.addr);
      resp_fresh      = (m.ep == epoch);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
      resp_fresh      = 1'b0;
    end
  end

  // Monitor: scores every delivered instruction and the buffer-visibility rules each cycle.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst) begin
      occ = 0;
    end else if (redirect_valid) begin
      check("if_valid_during_redirect", if_valid, 0);
      check("req_valid_during_redirect", imem_req_valid, 0);
      occ = 0;
    end else begin
      check("if_valid_vs_model", if_valid, occ != 0);
      if (!if_valid) begin
        check("empty_if_pc", if_pc, 0);
        check("empty_if_instr", if_instr, NOP);
      end
      if (if_valid && if_ready) begin
        check("stream_has_entry", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("if_pc", if_pc, e);
          check("if_instr", if_instr, mem_word(e));
        end
        delivered++;
      end
      occ = occ + int'(imem_resp_valid && resp_fresh) - int'(if_valid && if_ready);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_outst2(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (pend.size() == 2 && !imem_resp_valid) found = 1'b1;
    end
    check(name, found, 1);
  endtask

  initial begin
    int first;
    int nvalid;
    int d0;
    bit found;

    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_req_valid", imem_req_valid, 0);
    check("reset_if_valid", if_valid, 0);
    check("reset_if_instr", if_instr, NOP);
    check("reset_if_pc", if_pc, 0);

    // 1: reset release, 1-cycle memory, no stall
    tick();
    rst = 1'b1;
    restart_stream(64'h0);
    first = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (if_valid && first < 0) first = k;
    end
    check("reset_first_valid_latency", first, 2);
    nvalid = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (if_valid) nvalid++;
    end
    check("steady_no_bubbles", nvalid, 20);

    // 2: stall for 10 cycles
    tick();
    if_ready = 1'b0;
    repeat (10) @(negedge clk);
    check("stall_req_blocked", imem_req_valid, 0);
    check("stall_head_valid", if_valid, 1);
    tick();
    if_ready = 1'b1;
    repeat (20) tick();

    // 3: redirect to 0x100 with two requests in flight, 3-cycle memory
    mem_lat = 3;
    repeat (10) tick();
    wait_outst2("t3_outst2_seen");
    redirect_valid = 1'b1;
    redirect_pc    = 64'h100;
    restart_stream(64'h100);
    d0 = delivered;
    tick();
    redirect_valid = 1'b0;
    repeat (30) tick();
    check("t3_target_stream_delivered", delivered >= d0 + 5, 1);

    // 4: redirect coincident with a fresh response and a pop request, buffer nearly full
    mem_lat  = 2;
    if_ready = 1'b0;
    found    = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (occ == 3 && imem_resp_valid && resp_fresh) found = 1'b1;
    end
    check("t4_full_with_resp_seen", found, 1);
    if_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h500;
    restart_stream(64'h500);
    d0 = delivered;
    @(negedge clk);
    check("t4_no_pop_on_redirect", if_valid, 0);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t4_empty_after_flush", if_valid, 0);
    repeat (20) tick();
    check("t4_target_stream_delivered", delivered >= d0 + 5, 1);

    // 5: back-to-back redirects 0x200 then 0x300, 1-cycle memory
    mem_lat = 1;
    repeat (10) tick();
    watch_200      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h200;
    restart_stream(64'h200);
    tick();
    redirect_pc = 64'h300;
    restart_stream(64'h300);
    first = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (if_valid && first < 0) begin
        first = k;
        check("t5_first_pc", if_pc, 64'h300);
      end
      if (k == 0) begin
        tick();
        redirect_valid = 1'b0;
      end
    end
    check("t5_redirect_latency", first, 3);
    repeat (5) tick();
    watch_200 = 1'b0;
    check("t5_0x200_never_requested", saw_200, 0);

    // PC wrap across 2^64
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFF8;
    restart_stream(64'hFFFF_FFFF_FFFF_FFF8);
    d0 = delivered;
    tick();
    redirect_valid = 1'b0;
    repeat (10) tick();
    check("wrap_stream_delivered", delivered >= d0 + 4, 1);

    // 6: async reset mid-stream with two requests in flight
    mem_lat = 3;
    repeat (10) tick();
    wait_outst2("t6_outst2_seen");
    rst = 1'b0;
    epoch++;
    #1;
    check("t6_reset_req_valid", imem_req_valid, 0);
    check("t6_reset_if_valid", if_valid, 0);
    check("t6_reset_if_instr", if_instr, NOP);
    check("t6_reset_if_pc", if_pc, 0);
    tick();
    tick();
    rst = 1'b1;
    restart_stream(64'h0);
    d0 = delivered;
    repeat (30) tick();
    check("t6_restart_delivered", delivered >= d0 + 5, 1);

    // Randomized traffic: readiness, latency and redirects
    for (int c = 0; c < 600; c++) begin
      tick();
      if (c % 50 == 0) mem_lat = $urandom_range(1, 3);
      if_ready       = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = {32'($urandom), 32'($urandom)};
        redirect_pc[1:0] = 2'b00;
        restart_stream(redirect_pc);
      end else begin
        redirect_valid = 1'b0;
      end
    end
    tick();
    redirect_valid = 1'b0;
    if_ready       = 1'b1;
    imem_req_ready = 1'b1;
    repeat (10) tick();
    check("total_delivered", delivered > 200, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_fetch_unit
